// File: rtl/tlb_miss_arbiter_if.sv
// L1 TLB miss / L2 TLB request-response bundle for tlb_miss_arbiter.
// master: the arbiter side. slave: the surrounding L1/L2 TLB environment.
interface tlb_miss_arbiter_if #(
  parameter int unsigned ASID_WIDTH = 9,
  parameter int unsigned VPN_WIDTH  = 20,
  parameter int unsigned PTE_WIDTH  = 32
);
  logic                  itlb_req_valid;
  logic [ASID_WIDTH-1:0] itlb_req_ASID;
  logic [VPN_WIDTH-1:0]  itlb_req_VPN;
  logic                  itlb_req_ready;
  logic                  dtlb_req_valid;
  logic [ASID_WIDTH-1:0] dtlb_req_ASID;
  logic [VPN_WIDTH-1:0]  dtlb_req_VPN;
  logic                  dtlb_req_ready;
  logic                  l2_tlb_req_valid;
  logic                  l2_tlb_req_src;
  logic [ASID_WIDTH-1:0] l2_tlb_req_ASID;
  logic [VPN_WIDTH-1:0]  l2_tlb_req_VPN;
  logic                  l2_tlb_req_ready;
  logic                  l2_tlb_resp_valid;
  logic                  l2_tlb_resp_src;
  logic [PTE_WIDTH-1:0]  l2_tlb_resp_pte;
  logic                  l2_tlb_resp_is_superpage;
  logic                  itlb_resp_valid;
  logic [PTE_WIDTH-1:0]  itlb_resp_pte;
  logic                  itlb_resp_is_superpage;
  logic                  dtlb_resp_valid;
  logic [PTE_WIDTH-1:0]  dtlb_resp_pte;
  logic                  dtlb_resp_is_superpage;
  logic                  sfence_flush_valid;
  logic                  resp_err;

  modport master (
    input  itlb_req_valid, itlb_req_ASID, itlb_req_VPN,
    output itlb_req_ready,
    input  dtlb_req_valid, dtlb_req_ASID, dtlb_req_VPN,
    output dtlb_req_ready,
    output l2_tlb_req_valid, l2_tlb_req_src, l2_tlb_req_ASID, l2_tlb_req_VPN,
    input  l2_tlb_req_ready,
    input  l2_tlb_resp_valid, l2_tlb_resp_src, l2_tlb_resp_pte, l2_tlb_resp_is_superpage,
    output itlb_resp_valid, itlb_resp_pte, itlb_resp_is_superpage,
    output dtlb_resp_valid, dtlb_resp_pte, dtlb_resp_is_superpage,
    input  sfence_flush_valid,
    output resp_err
  );

  modport slave (
    output itlb_req_valid, itlb_req_ASID, itlb_req_VPN,
    input  itlb_req_ready,
    output dtlb_req_valid, dtlb_req_ASID, dtlb_req_VPN,
    input  dtlb_req_ready,
    input  l2_tlb_req_valid, l2_tlb_req_src, l2_tlb_req_ASID, l2_tlb_req_VPN,
    output l2_tlb_req_ready,
    output l2_tlb_resp_valid, l2_tlb_resp_src, l2_tlb_resp_pte, l2_tlb_resp_is_superpage,
    input  itlb_resp_valid, itlb_resp_pte, itlb_resp_is_superpage,
    input  dtlb_resp_valid, dtlb_resp_pte, dtlb_resp_is_superpage,
    output sfence_flush_valid,
    input  resp_err
  );
endinterface

// File: rtl/tlb_miss_arbiter.sv
// Shares the L2 TLB miss channel between ITLB (src 0) and DTLB (src 1).
// One outstanding miss per source; tagged L2 responses are routed back combinationally.
// Optional: define TLB_MISS_ARB_ITLB_PRIO_EN for fixed ITLB priority instead of round-robin.
module tlb_miss_arbiter #(
  parameter int unsigned ASID_WIDTH = 9,
  parameter int unsigned VPN_WIDTH  = 20,
  parameter int unsigned PTE_WIDTH  = 32
) (
  input logic              CLK,
  input logic              nRST,
  tlb_miss_arbiter_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StQueued, StSent} slot_e;

  slot_e                 slot_q [2];
  slot_e                 slot_d [2];
  logic [ASID_WIDTH-1:0] asid_q [2];
  logic [ASID_WIDTH-1:0] asid_d [2];
  logic [VPN_WIDTH-1:0]  vpn_q  [2];
  logic [VPN_WIDTH-1:0]  vpn_d  [2];

  // Remembers a stalled grant so a late-arriving competitor cannot switch the request.
  logic hold_vld_q, hold_vld_d;
  logic hold_src_q, hold_src_d;

  logic                  req_valid [2];
  logic [ASID_WIDTH-1:0] req_asid  [2];
  logic [VPN_WIDTH-1:0]  req_vpn   [2];
  logic                  queued    [2];
  logic                  arb_sel;
  logic                  sel;
  logic                  l2_valid;
  logic                  l2_fire;

  assign req_valid[0] = bus_io.itlb_req_valid;
  assign req_valid[1] = bus_io.dtlb_req_valid;
  assign req_asid[0]  = bus_io.itlb_req_ASID;
  assign req_asid[1]  = bus_io.dtlb_req_ASID;
  assign req_vpn[0]   = bus_io.itlb_req_VPN;
  assign req_vpn[1]   = bus_io.dtlb_req_VPN;
  assign queued[0]    = (slot_q[0] == StQueued);
  assign queued[1]    = (slot_q[1] == StQueued);
  assign l2_valid     = queued[0] | queued[1];
  assign l2_fire      = l2_valid & bus_io.l2_tlb_req_ready;

`ifdef TLB_MISS_ARB_ITLB_PRIO_EN
  // Fixed priority: ITLB whenever it has a queued miss.
  always_comb begin
    arb_sel = queued[0] ? 1'b0 : 1'b1;
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  // Round-robin pick between two queued slots; a lone queued slot always wins.
  always_comb begin
    arb_sel  = (queued[0] && queued[1]) ? rr_ptr_q : queued[1];
    rr_ptr_d = l2_fire ? ~sel : rr_ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Final grant and hold tracking; a flush may withdraw the held slot, which clears the hold.
  always_comb begin
    sel        = (hold_vld_q && queued[hold_src_q]) ? hold_src_q : arb_sel;
    hold_vld_d = l2_valid & ~bus_io.l2_tlb_req_ready & ~bus_io.sfence_flush_valid;
    hold_src_d = sel;
  end

  // Per-source slot next state and miss capture.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slot_d[s] = slot_q[s];
      asid_d[s] = asid_q[s];
      vpn_d[s]  = vpn_q[s];
      unique case (slot_q[s])
        StIdle: begin
          // A capture coinciding with a flush is dropped.
          if (req_valid[s] && !bus_io.sfence_flush_valid) begin
            slot_d[s] = StQueued;
            asid_d[s] = req_asid[s];
            vpn_d[s]  = req_vpn[s];
          end
        end
        StQueued: begin
          if (l2_fire && (sel == 1'(s))) slot_d[s] = StSent;
          else if (bus_io.sfence_flush_valid) slot_d[s] = StIdle;
        end
        StSent: begin
          if (bus_io.l2_tlb_resp_valid && (bus_io.l2_tlb_resp_src == 1'(s))) slot_d[s] = StIdle;
        end
        default: slot_d[s] = StIdle;
      endcase
    end
  end

  // Slot, capture and hold registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < 2; s++) begin
        slot_q[s] <= StIdle;
        asid_q[s] <= '0;
        vpn_q[s]  <= '0;
      end
      hold_vld_q <= 1'b0;
      hold_src_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        slot_q[s] <= slot_d[s];
        asid_q[s] <= asid_d[s];
        vpn_q[s]  <= vpn_d[s];
      end
      hold_vld_q <= hold_vld_d;
      hold_src_q <= hold_src_d;
    end
  end

  assign bus_io.itlb_req_ready   = (slot_q[0] == StIdle);
  assign bus_io.dtlb_req_ready   = (slot_q[1] == StIdle);
  assign bus_io.l2_tlb_req_valid = l2_valid;
  assign bus_io.l2_tlb_req_src   = l2_valid ? sel : 1'b0;
  assign bus_io.l2_tlb_req_ASID  = l2_valid ? asid_q[sel] : '0;
  assign bus_io.l2_tlb_req_VPN   = l2_valid ? vpn_q[sel] : '0;

  // Response demux; a response for a slot not awaiting one is still forwarded but flagged.
  always_comb begin
    bus_io.itlb_resp_valid        = 1'b0;
    bus_io.itlb_resp_pte          = '0;
    bus_io.itlb_resp_is_superpage = 1'b0;
    bus_io.dtlb_resp_valid        = 1'b0;
    bus_io.dtlb_resp_pte          = '0;
    bus_io.dtlb_resp_is_superpage = 1'b0;
    bus_io.resp_err               = 1'b0;
    if (bus_io.l2_tlb_resp_valid) begin
      bus_io.resp_err = (slot_q[bus_io.l2_tlb_resp_src] != StSent);
      if (bus_io.l2_tlb_resp_src) begin
        bus_io.dtlb_resp_valid        = 1'b1;
        bus_io.dtlb_resp_pte          = bus_io.l2_tlb_resp_pte;
        bus_io.dtlb_resp_is_superpage = bus_io.l2_tlb_resp_is_superpage;
      end else begin
        bus_io.itlb_resp_valid        = 1'b1;
        bus_io.itlb_resp_pte          = bus_io.l2_tlb_resp_pte;
        bus_io.itlb_resp_is_superpage = bus_io.l2_tlb_resp_is_superpage;
      end
    end
  end

endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Table-driven bench for tlb_miss_arbiter: one vector per clock cycle, outputs sampled at negedge.
module tb_tlb_miss_arbiter;

  logic CLK;
  logic nRST;

  tlb_miss_arbiter_if #(.ASID_WIDTH(9), .VPN_WIDTH(20), .PTE_WIDTH(32)) bus ();

  tlb_miss_arbiter #(.ASID_WIDTH(9), .VPN_WIDTH(20), .PTE_WIDTH(32)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus_io (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [8:0]  ia;
    logic [19:0] ivpn;
    logic        dv;
    logic [8:0]  da;
    logic [19:0] dvpn;
    logic        l2r;
    logic        fl;
    logic        rv;
    logic        rs;
    logic [31:0] pte;
    logic        sp;
    logic        e_ir;
    logic        e_dr;
    logic        e_lv;
    logic        e_ls;
    logic [8:0]  e_la;
    logic [19:0] e_lvpn;
    logic        e_iv;
    logic        e_dv;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;

  function automatic vec_t mk(
    input logic iv, input logic [8:0] ia, input logic [19:0] ivpn,
    input logic dv, input logic [8:0] da, input logic [19:0] dvpn,
    input logic l2r, input logic fl, input logic rv, input logic rs,
    input logic [31:0] pte, input logic sp,
    input logic e_ir, input logic e_dr, input logic e_lv, input logic e_ls,
    input logic [8:0] e_la, input logic [19:0] e_lvpn,
    input logic e_iv, input logic e_dv, input logic e_err);
    vec_t v;
    v.iv = iv; v.ia = ia; v.ivpn = ivpn; v.dv = dv; v.da = da; v.dvpn = dvpn;
    v.l2r = l2r; v.fl = fl; v.rv = rv; v.rs = rs; v.pte = pte; v.sp = sp;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_lv = e_lv; v.e_ls = e_ls;
    v.e_la = e_la; v.e_lvpn = e_lvpn; v.e_iv = e_iv; v.e_dv = e_dv; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [101:0] got_outs();
    return {bus.itlb_req_ready, bus.dtlb_req_ready, bus.l2_tlb_req_valid, bus.l2_tlb_req_src,
            bus.l2_tlb_req_ASID, bus.l2_tlb_req_VPN,
            bus.itlb_resp_valid, bus.itlb_resp_pte, bus.itlb_resp_is_superpage,
            bus.dtlb_resp_valid, bus.dtlb_resp_pte, bus.dtlb_resp_is_superpage,
            bus.resp_err};
  endfunction

  function automatic logic [101:0] exp_outs(input vec_t v);
    return {v.e_ir, v.e_dr, v.e_lv, v.e_ls, v.e_la, v.e_lvpn,
            v.e_iv, (v.e_iv ? v.pte : 32'h0), (v.e_iv ? v.sp : 1'b0),
            v.e_dv, (v.e_dv ? v.pte : 32'h0), (v.e_dv ? v.sp : 1'b0),
            v.e_err};
  endfunction

  task automatic drive(input vec_t v);
    bus.itlb_req_valid           = v.iv;
    bus.itlb_req_ASID            = v.ia;
    bus.itlb_req_VPN             = v.ivpn;
    bus.dtlb_req_valid           = v.dv;
    bus.dtlb_req_ASID            = v.da;
    bus.dtlb_req_VPN             = v.dvpn;
    bus.l2_tlb_req_ready         = v.l2r;
    bus.sfence_flush_valid       = v.fl;
    bus.l2_tlb_resp_valid        = v.rv;
    bus.l2_tlb_resp_src          = v.rs;
    bus.l2_tlb_resp_pte          = v.pte;
    bus.l2_tlb_resp_is_superpage = v.sp;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [101:0] got;
    logic [101:0] want;
    got  = got_outs();
    want = exp_outs(v);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Apply one vector for one cycle, compare mid-cycle, then advance past the clock edge.
  task automatic run_vec(input string name, input vec_t v);
    drive(v);
    @(negedge CLK);
    check(name, v);
    @(posedge CLK);
    #1;
  endtask

  vec_t idle_v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_v   = mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0);

    //        iv ia    ivpn      dv da    dvpn      l2r fl rv rs pte           sp
    //        ir dr lv ls la    lvpn      iv dv err
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,'h5,'h12345, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,1,1,0,'h5,'h12345, 0,0,0));
    vecs.push_back(mk(0,0,0, 1,'h7,'hABCDE, 0,0, 0,0,0,0, 0,1,1,0,'h5,'h12345, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,1,0,'h5,'h12345, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,0,'h5,'h12345, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,1,'h7,'hABCDE, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,32'h0ABCD00F,1, 0,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,32'h12345001,0, 0,1,0,0,0,0, 1,0,0));
    // Both requests together: ITLB then DTLB, twice.
    vecs.push_back(mk(1,'h1,'h11111, 1,'h2,'h22222, 1,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,0,'h1,'h11111, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,1,'h2,'h22222, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,32'h1,0, 0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,32'h2,1, 1,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(1,'h3,'h33333, 1,'h4,'h44444, 1,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,0,'h3,'h33333, 0,0,0));
    // Issue and response in the same cycle.
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 1,0,32'h3,0, 0,0,1,1,'h4,'h44444, 1,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,32'h4,0, 1,0,0,0,0,0, 0,1,0));
    // DTLB queued behind stalled channel, flushed; ITLB in flight unaffected.
    vecs.push_back(mk(1,'h8,'h88888, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 1,'h9,'h99999, 1,0, 0,0,0,0, 0,1,1,0,'h8,'h88888, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,1,1,'h9,'h99999, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,1, 0,0,0,0, 0,0,1,1,'h9,'h99999, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,32'h0ABCD123,0, 0,1,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    // Capture on a flush cycle is dropped.
    vecs.push_back(mk(1,'hA,'hAAAAA, 0,0,0, 0,1, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    // Stray response to an idle slot.
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,32'h55,1, 1,1,0,0,0,0, 1,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    // Handshake on a flush cycle still sends.
    vecs.push_back(mk(1,'hB,'hBBBBB, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,1, 0,0,0,0, 0,1,1,0,'hB,'hBBBBB, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,32'h6,0, 0,1,0,0,0,0, 1,0,0));
    // Stalled DTLB grant must not be stolen by a later ITLB miss.
    vecs.push_back(mk(0,0,0, 1,'hC,'hCCCCC, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 1,0,1,1,'hC,'hCCCCC, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,32'h7,0, 1,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,0, 1,'hD,'hDDDDD, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,'hE,'hEEEEE, 0,0,0, 0,0, 0,0,0,0, 1,0,1,1,'hD,'hDDDDD, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,1,1,'hD,'hDDDDD, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,1,'hD,'hDDDDD, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,1,0,'hE,'hEEEEE, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,32'h8,1, 0,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,32'h9,0, 0,1,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));

    // Reset state.
    nRST = 1'b0;
    drive(idle_v);
    @(negedge CLK);
    check("reset_state", idle_v);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while an ITLB miss is in flight: its late response is flagged.
    run_vec("mid_rst_req", mk(1,'h1F,'hFFFFF, 0,0,0, 0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    run_vec("mid_rst_issue", mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,1,1,0,'h1F,'hFFFFF, 0,0,0));
    nRST = 1'b0;
    drive(idle_v);
    @(negedge CLK);
    check("mid_rst_state", idle_v);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    run_vec("mid_rst_stray", mk(0,0,0, 0,0,0, 0,0, 1,0,32'hF,0, 1,1,0,0,0,0, 1,0,1));
    run_vec("mid_rst_after", idle_v);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb_miss_arbiter.md
Name: tlb_miss_arbiter

Overview:
- Shares the single L2 TLB miss-request channel between ITLB (src 0) and DTLB (src 1).
- Captures one outstanding miss per L1 TLB, issues them to the L2 TLB round-robin, and routes each tagged L2 response back to the L1 TLB that issued it.
- Sits between the L1 TLB miss registers and the L2 TLB. sfence flush discards queued, not-yet-issued misses.

Parameters:
ASID_WIDTH, 9, ASID field width
VPN_WIDTH, 20, virtual page number width (Sv32)
PTE_WIDTH, 32, packed PTE width

Ports:
CLK  in  1  clock
nRST  in  1  reset: nRST, asynchronous, active-low; clock CLK
itlb_req_valid  in  1  ITLB miss request
itlb_req_ASID  in  ASID_WIDTH  ITLB miss ASID
itlb_req_VPN  in  VPN_WIDTH  ITLB miss VPN
itlb_req_ready  out  1  ITLB slot free
dtlb_req_valid  in  1  DTLB miss request
dtlb_req_ASID  in  ASID_WIDTH  DTLB miss ASID
dtlb_req_VPN  in  VPN_WIDTH  DTLB miss VPN
dtlb_req_ready  out  1  DTLB slot free
l2_tlb_req_valid  out  1  request to L2 TLB
l2_tlb_req_src  out  1  0=ITLB, 1=DTLB
l2_tlb_req_ASID  out  ASID_WIDTH  issued ASID
l2_tlb_req_VPN  out  VPN_WIDTH  issued VPN
l2_tlb_req_ready  in  1  L2 TLB accepts
l2_tlb_resp_valid  in  1  L2 TLB response
l2_tlb_resp_src  in  1  returned source tag
l2_tlb_resp_pte  in  PTE_WIDTH  translated PTE
l2_tlb_resp_is_superpage  in  1  4MB page flag
itlb_resp_valid  out  1  response to ITLB
itlb_resp_pte  out  PTE_WIDTH  PTE to ITLB
itlb_resp_is_superpage  out  1  superpage flag to ITLB
dtlb_resp_valid  out  1  response to DTLB
dtlb_resp_pte  out  PTE_WIDTH  PTE to DTLB
dtlb_resp_is_superpage  out  1  superpage flag to DTLB
sfence_flush_valid  in  1  drop queued (unissued) misses
resp_err  out  1  one-cycle pulse: response for source not in SENT

Behaviour:
- Per-source slot FSM, one per source:
  - IDLE -> QUEUED on req_valid & req_ready; capture ASID/VPN.
  - QUEUED -> SENT on l2 handshake for that source.
  - SENT -> IDLE on l2_tlb_resp_valid with a matching src.
- req_ready = (slot == IDLE), registered-state based. A source returning to IDLE at cycle N may issue a new request no earlier than N+1.
- Issue:
  - l2_tlb_req_valid = any slot QUEUED. Request fields are driven from the captured slot registers.
  - Selection: if both slots are QUEUED, pick the slot pointed to by rr_ptr; otherwise pick the single QUEUED slot.
  - rr_ptr toggles to the non-granted source on each handshake.
  - The selected source and its fields hold stable while valid & ~ready.
- Latency: request accepted at cycle N -> l2_tlb_req_valid no earlier than N+1.
- Response routing is combinational, same cycle:
  - src 0 -> itlb_resp_valid/pte/is_superpage.
  - src 1 -> dtlb_resp_* outputs.
  - Non-selected outputs drive valid 0 and PTE/superpage 0.
- Response whose src slot is not SENT: still forwarded, resp_err pulses 1 for one cycle, slot state unchanged.
- sfence_flush_valid: every QUEUED slot -> IDLE next cycle.
  - SENT slots are unaffected; their responses are forwarded normally.
  - A request handshake on the same cycle as flush: the issued slot goes to SENT.
  - A new capture (IDLE->QUEUED) on the same cycle as flush is dropped; the slot stays IDLE.
- Simultaneous response and issue in one cycle: both take effect independently.
- Reset values:
  - Both slots IDLE, rr_ptr=0 (ITLB first).
  - itlb_req_ready=1, dtlb_req_ready=1.
  - l2_tlb_req_valid=0, all resp_valid=0, resp_err=0, data outputs 0.
- Reset mid-operation: all slots return to IDLE; any in-flight L2 response after reset sets resp_err.

Optional Feature:
- Macro TLB_MISS_ARB_ITLB_PRIO_EN.
- When defined: fixed priority. ITLB wins whenever its slot is QUEUED; rr_ptr is not implemented.
- When undefined: round-robin as specified above.

Test Plan:
- Reset, then itlb_req (ASID=0x5, VPN=0x12345) -> itlb_req_ready=0 next cycle; l2_tlb_req_valid=1, src=0, VPN=0x12345 one cycle after accept.
- ITLB and DTLB requests accepted in the same cycle, l2 ready=1 -> ITLB issued first, DTLB the following cycle; a repeat of both issues in the same order again because rr_ptr points to ITLB after the DTLB grant.
- l2_tlb_req_ready held 0 for 3 cycles -> req_valid/src/ASID/VPN remain stable; handshake on cycle 4.
- l2 resp src=1, pte=0x0ABCD00F, is_superpage=1 -> dtlb_resp_valid=1 same cycle with those values, itlb_resp_valid=0; dtlb_req_ready=1 next cycle.
- DTLB QUEUED behind stalled ITLB, sfence_flush_valid pulsed -> DTLB slot IDLE, no DTLB l2 request issued; later ITLB response forwarded normally.
- Response with src=0 while ITLB slot IDLE -> itlb_resp_valid=1, resp_err=1 for exactly one cycle.
